alu_word_sequencer: RTL and testbench
=====================================

Name: alu_word_sequencer

Overview:
Multi-cycle controller that runs one wide (8*NBYTES-bit) operation through the existing 8-bit combinational ALU, one byte per cycle, LSB first.
- Carry is chained between bytes.
- Sits between a requester (start/done handshake) and the single ALU instance. It owns the ALU's A, B, op_code and c_in inputs.
- Makes the 8-bit ALU usable for 32-bit add, subtract, OR and AND.

Parameters:
NBYTES, 4, number of 8-bit slices per operation (>=2); word width W = 8*NBYTES

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request pulse; sampled only when state is IDLE or DONE
op  in  2  00 add, 01 subtract, 10 OR, 11 AND (ALU op_code encoding)
opa  in  W  operand A; captured with start
opb  in  W  operand B; captured with start
cin  in  1  carry in for byte 0; captured with start; caller drives 1 for true subtract
busy  out  1  high while state is RUN
done  out  1  one-cycle pulse, result/cout valid
result  out  W  assembled result; held until next accepted start
cout  out  1  carry out of final byte; 0 for OR/AND
alu_a  out  8  to ALU A
alu_b  out  8  to ALU B
alu_op_code  out  2  to ALU op_code
alu_c_in  out  1  to ALU c_in
alu_y  in  8  from ALU y (combinational)
alu_c_out  in  1  from ALU c_out

Behaviour:
- ALU contract relied on:
  - 00: y = A+B+c_in; c_out = carry.
  - 01: y = A+~B+c_in; c_out = carry (1 = no borrow).
  - 10/11: bitwise; c_out ignored.
- Reset (async, rst_n=0):
  - State is IDLE and byte index is 0.
  - busy, done, result, cout, alu_a, alu_b, alu_op_code and alu_c_in are all 0.
  - A reset mid-RUN aborts the operation; no done is produced.
- States:
  - IDLE: ALU outputs driven 0. On start go to RUN and latch opa, opb, op and cin. carry_q <= cin for op 00/01, else 0. idx <= 0; result cleared to 0.
  - RUN, at each edge:
    - Capture alu_y into result[8*idx +: 8].
    - For op 00/01, carry_q <= alu_c_out.
    - If idx == NBYTES-1, go to DONE; else idx++.
  - RUN combinational outputs:
    - alu_a = opa_q byte idx, alu_b = opb_q byte idx.
    - alu_op_code = op_q, alu_c_in = carry_q (0 for OR/AND).
  - DONE: done=1 for exactly this cycle; cout = carry_q (0 for OR/AND). If start, go directly to RUN (back-to-back, same latch actions as IDLE); else go to IDLE.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E_NBYTES, i.e. NBYTES cycles. Throughput is one op per NBYTES+1 cycles when back-to-back.
- start while in RUN is ignored, with no queueing. opa/opb/op changes during RUN have no effect.
- result and cout are registered and stable from the done cycle until the next accepted start. cout updates only on the transition into DONE.
- Subtract borrow-wrap: 1-2 yields all-ones with cout=0, with no special handling.

Optional Feature:
Macro ALU_SEQ_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), the signed overflow of the W-bit add/subtract.
  - Let a = opa_q MSB, b = opb_q MSB for add or ~opb_q MSB for subtract, r = result MSB. Then ovf = (a==b) && (r!=a).
  - Registered with cout; 0 for OR/AND.
- Not defined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset, then add with NBYTES=4: opa=0x000000FF, opb=0x00000001, cin=0 -> result=0x00000100, cout=0, done exactly 4 cycles after start; busy high 4 cycles.
2. Carry ripple across all bytes: add 0xFFFFFFFF + 0x00000000, cin=1 -> result=0x00000000, cout=1. alu_c_in must be seen as 1,1,1,1 across the four RUN cycles.
3. Subtract (op=01, cin=1):
   - 0x00000100 - 0x00000001 -> 0x000000FF, cout=1.
   - 0x00000001 - 0x00000002 -> 0xFFFFFFFF, cout=0.
4. Logic ops on opa=0xF0F0F0F0, opb=0x0F0F00FF:
   - OR -> 0xFFFFF0FF, cout=0.
   - AND -> 0x000000F0, cout=0.
   - alu_c_in is 0 throughout.
5. Control and reset:
   - start pulsed mid-RUN with other operands -> ignored, first result unchanged.
   - start asserted in the DONE cycle -> new op begins immediately; busy rises the next cycle.
   - rst_n low mid-RUN -> all outputs 0 asynchronously, no done.
6. With ALU_SEQ_OVF_EN:
   - 0x7FFFFFFF + 0x00000001, cin=0 -> result=0x80000000, ovf=1.
   - 0x80000000 - 0x00000001 (cin=1) -> 0x7FFFFFFF, ovf=1.
   - 0x5 + 0x3 -> ovf=0.

Source files
------------

// File: rtl/alu_word_sequencer_if.sv
// alu_word_sequencer_if: requester handshake and 8-bit ALU signals of alu_word_sequencer.
// ovf exists only when ALU_SEQ_OVF_EN is defined.
interface alu_word_sequencer_if #(parameter int NBYTES = 4);
    localparam int W = 8 * NBYTES;
    logic start;
    logic [1:0] op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic cin;
    logic busy;
    logic done;
    logic [W-1:0] result;
    logic cout;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op_code;
    logic alu_c_in;
    logic [7:0] alu_y;
    logic alu_c_out;
`ifdef ALU_SEQ_OVF_EN
    logic ovf;
`endif
    modport slave (
        input start, op, opa, opb, cin, alu_y, alu_c_out,
        output busy, done, result, cout, alu_a, alu_b, alu_op_code, alu_c_in
`ifdef ALU_SEQ_OVF_EN
        , output ovf
`endif
    );
    modport master (
        output start, op, opa, opb, cin, alu_y, alu_c_out,
        input busy, done, result, cout, alu_a, alu_b, alu_op_code, alu_c_in
`ifdef ALU_SEQ_OVF_EN
        , input ovf
`endif
    );
endinterface

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs a W-bit add/sub/OR/AND through one 8-bit ALU, LSB byte first, carry chained.
// Define ALU_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module alu_word_sequencer #(
    parameter int NBYTES = 4
) (
    input logic clk,
    input logic rst_n,
    alu_word_sequencer_if.slave bus
);
    localparam int W = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state;
    state_t state_n;
    logic [IW-1:0] idx;
    logic [W-1:0] opa_q;
    logic [W-1:0] opb_q;
    logic [W-1:0] result_q;
    logic [1:0] op_q;
    logic carry_q;
    logic cout_q;
    logic accept;
    logic last;
    logic arith;
`ifdef ALU_SEQ_OVF_EN
    logic ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        accept = (state != RUN) && bus.start;
        last = idx == IW'(NBYTES - 1);
        arith = !op_q[1];
        state_n = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
        bus.busy = state == RUN;
        bus.done = state == DONE;
        bus.alu_a = bus.busy ? opa_q[8*idx +: 8] : 8'd0;
        bus.alu_b = bus.busy ? opb_q[8*idx +: 8] : 8'd0;
        bus.alu_op_code = bus.busy ? op_q : 2'd0;
        bus.alu_c_in = bus.busy && carry_q;
        bus.result = result_q;
        bus.cout = cout_q;
`ifdef ALU_SEQ_OVF_EN
        bus.ovf = ovf_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            opa_q <= '0;
            opb_q <= '0;
            op_q <= '0;
            carry_q <= 1'b0;
            result_q <= '0;
            cout_q <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (accept) begin
            opa_q <= bus.opa;
            opb_q <= bus.opb;
            op_q <= bus.op;
            carry_q <= bus.cin && !bus.op[1];
            idx <= '0;
            result_q <= '0;
        end else if (state == RUN) begin
            result_q[8*idx +: 8] <= bus.alu_y;
            if (arith) carry_q <= bus.alu_c_out;
            if (last) begin
                cout_q <= arith && bus.alu_c_out;
`ifdef ALU_SEQ_OVF_EN
                // subtract compares against the inverted B sign, matching what the ALU adds
                ovf_q <= arith && (opa_q[W-1] == (opb_q[W-1] ^ op_q[0])) && (bus.alu_y[7] != opa_q[W-1]);
`endif
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb_alu_word_sequencer: randomized and directed checks of alu_word_sequencer against a word-level model.
// Contains the 8-bit ALU behavioural model that the sequencer drives.
module tb_alu_word_sequencer;
    localparam int NB = 4;
    localparam int W = 8 * NB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int fails = 0;
    int lat;
    int busy_n;
    logic cq[$];
    logic [8:0] alu_sum;

    always #5 clk = ~clk;

    alu_word_sequencer_if #(.NBYTES(NB)) bus();
    alu_word_sequencer #(.NBYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // The ALU drives c_out=1 on logic ops so an ungated carry shows up at cout
    always_comb begin
        alu_sum = bus.alu_op_code[0] ? {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 9'(bus.alu_c_in)
                                     : {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + 9'(bus.alu_c_in);
        bus.alu_y = bus.alu_op_code == 2'b10 ? (bus.alu_a | bus.alu_b) :
                    bus.alu_op_code == 2'b11 ? (bus.alu_a & bus.alu_b) : alu_sum[7:0];
        bus.alu_c_out = bus.alu_op_code[1] ? 1'b1 : alu_sum[8];
    end

    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0] s;
        longint sv;
        case (op)
            2'b00: s = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            2'b01: s = {1'b0, a} + {1'b0, ~b} + (W+1)'(c);
            2'b10: s = {1'b0, a | b};
            default: s = {1'b0, a & b};
        endcase
        r = s[W-1:0];
        co = s[W];
        sv = op[0] ? longint'($signed(a)) - longint'($signed(b)) - 1 + longint'(c)
                   : longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        ov = !op[1] && (sv != longint'($signed(r)));
    endfunction

    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.start = 1'b1;
        bus.op = op;
        bus.opa = a;
        bus.opb = b;
        bus.cin = c;
    endtask

    task automatic wait_done(input string name);
        lat = -1;
        busy_n = 0;
        cq.delete();
        checks++;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                lat = k - 1;
                return;
            end
            if (bus.busy) begin
                busy_n++;
                cq.push_back(bus.alu_c_in);
            end
        end
        fails++;
        $display("FAIL %s timeout: done not seen within 50 cycles", name);
    endtask

    function automatic logic [4:0] trace();
        logic [4:0] v = '0;
        v[4] = cq.size() == NB;
        for (int i = 0; i < cq.size() && i < NB; i++) v[i] = cq[i];
        return v;
    endfunction

    task automatic test_reset();
        #1;
        if ({bus.busy, bus.done, bus.cout, bus.alu_c_in, bus.alu_op_code} !== 6'd0) begin fails++; $display("FAIL reset ctrl: got %b want 000000", {bus.busy, bus.done, bus.cout, bus.alu_c_in, bus.alu_op_code}); end checks++;
        if (bus.result !== '0) begin fails++; $display("FAIL reset result: got %h want 0", bus.result); end checks++;
        if ({bus.alu_a, bus.alu_b} !== 16'd0) begin fails++; $display("FAIL reset alu ab: got %h want 0", {bus.alu_a, bus.alu_b}); end checks++;
`ifdef ALU_SEQ_OVF_EN
        if (bus.ovf !== 1'b0) begin fails++; $display("FAIL reset ovf: got %b want 0", bus.ovf); end checks++;
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle busy: got %b want 0", bus.busy); end checks++;
    endtask

    task automatic test_add();
        logic [W-1:0] er;
        logic ec, eo;
        @(negedge clk);
        launch(2'b00, 32'h000000FF, 32'h00000001, 1'b0);
        wait_done("add");
        model(2'b00, 32'h000000FF, 32'h00000001, 1'b0, er, ec, eo);
        if (bus.result !== er) begin fails++; $display("FAIL add result: got %h want %h", bus.result, er); end checks++;
        if (bus.cout !== ec) begin fails++; $display("FAIL add cout: got %b want %b", bus.cout, ec); end checks++;
        if (lat !== NB) begin fails++; $display("FAIL add latency: got %0d want %0d", lat, NB); end checks++;
        if (busy_n !== NB) begin fails++; $display("FAIL add busy cycles: got %0d want %0d", busy_n, NB); end checks++;
        @(negedge clk);
        @(negedge clk);
        if ({bus.done, bus.busy} !== 2'b00) begin fails++; $display("FAIL add done pulse: got %b want 00", {bus.done, bus.busy}); end checks++;
        if (bus.result !== er) begin fails++; $display("FAIL add result held: got %h want %h", bus.result, er); end checks++;
        launch(2'b00, 32'hFFFFFFFF, 32'h00000000, 1'b1);
        wait_done("ripple");
        model(2'b00, 32'hFFFFFFFF, 32'h00000000, 1'b1, er, ec, eo);
        if ({bus.cout, bus.result} !== {ec, er}) begin fails++; $display("FAIL ripple cout/result: got %h want %h", {bus.cout, bus.result}, {ec, er}); end checks++;
        if (trace() !== 5'b11111) begin fails++; $display("FAIL ripple c_in trace: got %b want 11111", trace()); end checks++;
    endtask

    task automatic test_subtract();
        logic [W-1:0] av[2] = '{32'h00000100, 32'h00000001};
        logic [W-1:0] bv[2] = '{32'h00000001, 32'h00000002};
        logic [W-1:0] er;
        logic ec, eo;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            launch(2'b01, av[i], bv[i], 1'b1);
            wait_done("sub");
            model(2'b01, av[i], bv[i], 1'b1, er, ec, eo);
            if (bus.result !== er) begin fails++; $display("FAIL sub%0d result: got %h want %h", i, bus.result, er); end checks++;
            if (bus.cout !== ec) begin fails++; $display("FAIL sub%0d cout: got %b want %b", i, bus.cout, ec); end checks++;
        end
    endtask

    task automatic test_logic();
        logic [W-1:0] er;
        logic ec, eo;
        for (int i = 2; i < 4; i++) begin
            @(negedge clk);
            launch(2'(i), 32'hF0F0F0F0, 32'h0F0F00FF, 1'b1);
            wait_done("logic");
            model(2'(i), 32'hF0F0F0F0, 32'h0F0F00FF, 1'b1, er, ec, eo);
            if (bus.result !== er) begin fails++; $display("FAIL logic op%0d result: got %h want %h", i, bus.result, er); end checks++;
            if (bus.cout !== 1'b0) begin fails++; $display("FAIL logic op%0d cout: got %b want 0", i, bus.cout); end checks++;
            if (trace() !== 5'b10000) begin fails++; $display("FAIL logic op%0d c_in trace: got %b want 10000", i, trace()); end checks++;
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] er;
        logic ec, eo;
        @(negedge clk);
        launch(2'b00, 32'h12345678, 32'h01010101, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        launch(2'b01, 32'hDEADBEEF, 32'h00000001, 1'b1);
        wait_done("ignore");
        model(2'b00, 32'h12345678, 32'h01010101, 1'b0, er, ec, eo);
        if (bus.result !== er) begin fails++; $display("FAIL ignore result: got %h want %h", bus.result, er); end checks++;
        if (bus.cout !== ec) begin fails++; $display("FAIL ignore cout: got %b want %b", bus.cout, ec); end checks++;
        @(negedge clk);
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL ignore queued: busy got %b want 0", bus.busy); end checks++;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] er;
        logic ec, eo;
        @(negedge clk);
        launch(2'b00, 32'h89ABCDEF, 32'h76543211, 1'b0);
        wait_done("b2b first");
        model(2'b00, 32'h89ABCDEF, 32'h76543211, 1'b0, er, ec, eo);
        if ({bus.cout, bus.result} !== {ec, er}) begin fails++; $display("FAIL b2b first: got %h want %h", {bus.cout, bus.result}, {ec, er}); end checks++;
        launch(2'b01, 32'h00000000, 32'h00000001, 1'b1);
        wait_done("b2b second");
        model(2'b01, 32'h00000000, 32'h00000001, 1'b1, er, ec, eo);
        if ({bus.cout, bus.result} !== {ec, er}) begin fails++; $display("FAIL b2b second: got %h want %h", {bus.cout, bus.result}, {ec, er}); end checks++;
        if (lat !== NB) begin fails++; $display("FAIL b2b latency: got %0d want %0d", lat, NB); end checks++;
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        @(negedge clk);
        launch(2'b00, 32'h11111111, 32'h22222222, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        if ({bus.busy, bus.done, bus.cout, bus.alu_c_in, bus.alu_op_code} !== 6'd0) begin fails++; $display("FAIL midrst ctrl: got %b want 000000", {bus.busy, bus.done, bus.cout, bus.alu_c_in, bus.alu_op_code}); end checks++;
        if ({bus.result, bus.alu_a, bus.alu_b} !== '0) begin fails++; $display("FAIL midrst data: got %h want 0", {bus.result, bus.alu_a, bus.alu_b}); end checks++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        if (seen !== 0) begin fails++; $display("FAIL midrst done after abort: got %0d active cycles want 0", seen); end checks++;
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, er;
        logic [1:0] op;
        logic c, ec, eo;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            c = 1'($urandom_range(0, 1));
            launch(op, a, b, c);
            wait_done("random");
            model(op, a, b, c, er, ec, eo);
            if (bus.result !== er) begin fails++; $display("FAIL rnd%0d result op%0d %h %h %b: got %h want %h", i, op, a, b, c, bus.result, er); end checks++;
            if (bus.cout !== ec) begin fails++; $display("FAIL rnd%0d cout: got %b want %b", i, bus.cout, ec); end checks++;
`ifdef ALU_SEQ_OVF_EN
            if (bus.ovf !== eo) begin fails++; $display("FAIL rnd%0d ovf: got %b want %b", i, bus.ovf, eo); end checks++;
`endif
            if (lat !== NB) begin fails++; $display("FAIL rnd%0d latency: got %0d want %0d", i, lat, NB); end checks++;
        end
    endtask

`ifdef ALU_SEQ_OVF_EN
    task automatic test_ovf();
        logic [1:0] ov[3] = '{2'b00, 2'b01, 2'b00};
        logic [W-1:0] av[3] = '{32'h7FFFFFFF, 32'h80000000, 32'h00000005};
        logic [W-1:0] bv[3] = '{32'h00000001, 32'h00000001, 32'h00000003};
        logic cv[3] = '{1'b0, 1'b1, 1'b0};
        logic [W-1:0] er;
        logic ec, eo;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            launch(ov[i], av[i], bv[i], cv[i]);
            wait_done("ovf");
            model(ov[i], av[i], bv[i], cv[i], er, ec, eo);
            if (bus.result !== er) begin fails++; $display("FAIL ovf%0d result: got %h want %h", i, bus.result, er); end checks++;
            if (bus.ovf !== eo) begin fails++; $display("FAIL ovf%0d flag: got %b want %b", i, bus.ovf, eo); end checks++;
        end
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.opa = '0;
        bus.opb = '0;
        bus.cin = 1'b0;
        test_reset();
        test_add();
        test_subtract();
        test_logic();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_run();
`ifdef ALU_SEQ_OVF_EN
        test_ovf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
